// File: rtl/sym_vn_lut_pingpong.sv
// sym_vn_lut_pingpong
// Symmetric VN lookup table with two pages. The active page serves
// READ_PORTS parallel lookups while a loader streams a new table into the
// shadow page and then swaps the two pages, so reads are never stalled.
// Optional feature macro: SYM_VN_LUT_OUTREG_EN (registered read outputs,
// one cycle of read latency). Default build: combinational reads.
module sym_vn_lut_pingpong #(
  parameter int QUAN_SIZE  = 4,
  parameter int ADDR_W     = 7,
  parameter int READ_PORTS = 2
) (
  input  logic                             write_clk,
  input  logic                             rstn,
  input  logic                             load_start,
  input  logic                             load_abort,
  input  logic                             load_valid,
  input  logic [QUAN_SIZE-1:0]             load_data,
  output logic                             load_ready,
  output logic                             load_done,
  output logic                             lut_ready,
  output logic                             active_page,
  input  logic [READ_PORTS*ADDR_W-1:0]     read_addr,
  output logic [READ_PORTS*QUAN_SIZE-1:0]  lut_data
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SWAP = 2'd2
  } state_t;

  state_t                          state_r;
  state_t                          state_nxt_s;
  logic [ADDR_W-1:0]               wr_addr_r;
  logic [ADDR_W-1:0]               wr_addr_nxt_s;
  logic                            beat_s;
  logic                            load_ready_r;
  logic                            load_done_r;
  logic                            lut_ready_r;
  logic                            active_page_r;
  logic [READ_PORTS*QUAN_SIZE-1:0] rd_data_s;

  // Page storage: index = {page, address}; deliberately not reset so a
  // table survives a reset pulse.
  logic [QUAN_SIZE-1:0] mem_r [0:2*DEPTH-1];

  // A beat is accepted only while loading; an abort in the same cycle wins.
  always_comb begin
    beat_s = 1'b0;
    if ((state_r == ST_LOAD) && load_valid && !load_abort) begin
      beat_s = 1'b1;
    end else begin
      beat_s = 1'b0;
    end
  end

  // Loader next-state and write-address logic.
  always_comb begin
    state_nxt_s   = state_r;
    wr_addr_nxt_s = wr_addr_r;
    case (state_r)
      ST_IDLE: begin
        if (load_start && !load_abort) begin
          state_nxt_s   = ST_LOAD;
          wr_addr_nxt_s = '0;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (load_abort) begin
          state_nxt_s = ST_IDLE;
        end else if (beat_s && (wr_addr_r == LAST_ADDR)) begin
          // Final entry written: hold the address, go swap pages.
          state_nxt_s = ST_SWAP;
        end else if (beat_s) begin
          wr_addr_nxt_s = wr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_SWAP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        wr_addr_nxt_s = '0;
      end
    endcase
  end

  // Loader state, handshake/status flags and page select registers.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= ST_IDLE;
      wr_addr_r     <= '0;
      load_ready_r  <= 1'b0;
      load_done_r   <= 1'b0;
      lut_ready_r   <= 1'b0;
      active_page_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      wr_addr_r     <= wr_addr_nxt_s;
      load_ready_r  <= (state_nxt_s == ST_LOAD);
      load_done_r   <= (state_nxt_s == ST_SWAP);
      // The page flips at the end of the swap cycle, so the new table is
      // visible from the cycle after load_done.
      active_page_r <= active_page_r ^ (state_r == ST_SWAP);
      lut_ready_r   <= lut_ready_r | (state_r == ST_SWAP);
    end
  end

  // Accepted beats land in the shadow page.
  always_ff @(posedge write_clk) begin
    if (beat_s) begin
      mem_r[{~active_page_r, wr_addr_r}] <= load_data;
    end
  end

  // Parallel reads from the active page; zero until a table is complete.
  always_comb begin
    rd_data_s = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (lut_ready_r) begin
        rd_data_s[p*QUAN_SIZE +: QUAN_SIZE] =
          mem_r[{active_page_r, read_addr[p*ADDR_W +: ADDR_W]}];
      end else begin
        rd_data_s[p*QUAN_SIZE +: QUAN_SIZE] = '0;
      end
    end
  end

  assign load_ready  = load_ready_r;
  assign load_done   = load_done_r;
  assign lut_ready   = lut_ready_r;
  assign active_page = active_page_r;

`ifdef SYM_VN_LUT_OUTREG_EN
  logic [READ_PORTS*QUAN_SIZE-1:0] lut_data_r;

  // Per-port output register: one cycle of read latency.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      lut_data_r <= '0;
    end else begin
      lut_data_r <= rd_data_s;
    end
  end

  assign lut_data = lut_data_r;
`else
  assign lut_data = rd_data_s;
`endif

endmodule

// File: tb/tb_sym_vn_lut_pingpong.sv
// Self-checking bench for sym_vn_lut_pingpong (4 read ports, depth 128).
// Table-driven read vectors through an expected-value queue, plus
// hand-written load / abort / reset sequences.
module tb_sym_vn_lut_pingpong;

  localparam int Q  = 4;
  localparam int AW = 7;
  localparam int RP = 4;
  localparam int D  = 128;

  logic          clk;
  logic          rstn;
  logic          load_start;
  logic          load_abort;
  logic          load_valid;
  logic [Q-1:0]  load_data;
  logic          load_ready;
  logic          load_done;
  logic          lut_ready;
  logic          active_page;
  logic [RP*AW-1:0] read_addr;
  logic [RP*Q-1:0]  lut_data;

  sym_vn_lut_pingpong #(.QUAN_SIZE(Q), .ADDR_W(AW), .READ_PORTS(RP)) dut (
    .write_clk  (clk),
    .rstn       (rstn),
    .load_start (load_start),
    .load_abort (load_abort),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .lut_ready  (lut_ready),
    .active_page(active_page),
    .read_addr  (read_addr),
    .lut_data   (lut_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               phase;
    logic [RP*AW-1:0] addrs;
    logic [RP*Q-1:0]  exp;
  } vec_t;

  vec_t vecs[9];

  int total = 0;
  int bad   = 0;

  logic [Q-1:0]    model [2][D];
  logic            exp_page;
  logic            exp_ready;
  logic [RP*Q-1:0] exp_q[$];
  logic [RP*Q-1:0] prev_exp;
  logic            prev_valid;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Drive one read vector, queue its expectation, pop and compare on output.
  task automatic rd_vec(input logic [RP*AW-1:0] addrs, input logic [RP*Q-1:0] exp,
                        input string nm);
    logic [RP*Q-1:0] want;
    @(posedge clk); #1;
    read_addr = addrs;
    exp_q.push_back(exp);
`ifdef SYM_VN_LUT_OUTREG_EN
    #1;
    if (prev_valid) chk({nm, "_hold"}, lut_data, prev_exp);
    @(posedge clk); #1;
`else
    #1;
`endif
    want = exp_q.pop_front();
    chk(nm, lut_data, want);
    prev_exp   = exp;
    prev_valid = 1'b1;
  endtask

  task automatic run_phase(input int ph);
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].phase == ph) rd_vec(vecs[i].addrs, vecs[i].exp, $sformatf("rd_p%0d_v%0d", ph, i));
    end
  endtask

  // Load nbeats entries into the shadow page; mode 0 = complete,
  // mode 1 = abort afterwards, mode 2 = async reset afterwards.
  task automatic load_page(input int nbeats, input bit inv, input int mode, input string nm);
    int            beats;
    int            guard;
    bit            v;
    logic [Q-1:0]  d;
    logic [Q-1:0]  m;
    logic [RP*Q-1:0] exp_rd;
    prev_valid = 1'b0;
    @(posedge clk); #1;
    read_addr  = {RP{7'h7F}};
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    chk({nm, "_ready_on"}, {31'd0, load_ready}, 32'd1);
    beats = 0;
    guard = 0;
    while (beats < nbeats && guard < 4000) begin
      v = ($urandom_range(0, 3) != 0);
      d = inv ? ~beats[3:0] : beats[3:0];
      load_valid = v;
      load_data  = d;
      load_start = (guard == 5);
      if (v) begin
        model[~exp_page][beats] = d;
        beats++;
      end
      m      = model[exp_page][D-1];
      exp_rd = exp_ready ? {RP{m}} : '0;
      chk({nm, "_rd_during"}, lut_data, exp_rd);
      chk({nm, "_no_done"}, {31'd0, load_done}, 32'd0);
      @(posedge clk); #1;
      guard++;
    end
    load_start = 1'b0;
    load_valid = 1'b0;
    if (guard >= 4000) chk({nm, "_timeout"}, 32'd1, 32'd0);
    if (mode == 1) begin
      load_abort = 1'b1;
      load_valid = 1'b1;
      load_data  = 4'h9;
      @(posedge clk); #1;
      load_abort = 1'b0;
      load_valid = 1'b0;
      chk({nm, "_abort_idle"}, {31'd0, load_ready}, 32'd0);
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        chk({nm, "_abort_nodone"}, {31'd0, load_done}, 32'd0);
        chk({nm, "_abort_page"}, {31'd0, active_page}, {31'd0, exp_page});
      end
    end else if (mode == 2) begin
      rstn = 1'b0;
      #1;
      chk({nm, "_rst_ready"}, {31'd0, load_ready}, 32'd0);
      chk({nm, "_rst_lutrdy"}, {31'd0, lut_ready}, 32'd0);
      chk({nm, "_rst_data"}, lut_data, 32'd0);
      chk({nm, "_rst_page"}, {31'd0, active_page}, 32'd0);
      exp_page  = 1'b0;
      exp_ready = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
    end else begin
      chk({nm, "_done"}, {31'd0, load_done}, 32'd1);
      chk({nm, "_swap_notready"}, {31'd0, load_ready}, 32'd0);
      chk({nm, "_page_old"}, {31'd0, active_page}, {31'd0, exp_page});
      @(posedge clk); #1;
      exp_page  = ~exp_page;
      exp_ready = 1'b1;
      chk({nm, "_done_pulse"}, {31'd0, load_done}, 32'd0);
      chk({nm, "_page_new"}, {31'd0, active_page}, {31'd0, exp_page});
      chk({nm, "_lut_ready"}, {31'd0, lut_ready}, 32'd1);
    end
    prev_valid = 1'b0;
  endtask

  initial begin
    // Port p0 is the least significant field of each concatenation.
    vecs[0] = '{0, {7'h40, 7'h7F, 7'h7F, 7'h00}, {4'h0, 4'hF, 4'hF, 4'h0}};
    vecs[1] = '{0, {7'h25, 7'h25, 7'h1A, 7'h33}, {4'h5, 4'h5, 4'hA, 4'h3}};
    vecs[2] = '{0, {7'h01, 7'h02, 7'h7E, 7'h10}, {4'h1, 4'h2, 4'hE, 4'h0}};
    vecs[3] = '{1, {7'h40, 7'h7F, 7'h7F, 7'h00}, {4'hF, 4'h0, 4'h0, 4'hF}};
    vecs[4] = '{1, {7'h25, 7'h25, 7'h1A, 7'h33}, {4'hA, 4'hA, 4'h5, 4'hC}};
    vecs[5] = '{1, {7'h01, 7'h02, 7'h7E, 7'h10}, {4'hE, 4'hD, 4'h1, 4'hF}};
    vecs[6] = '{2, {7'h40, 7'h7F, 7'h7F, 7'h00}, {4'hF, 4'h0, 4'h0, 4'hF}};
    vecs[7] = '{2, {7'h25, 7'h25, 7'h1A, 7'h33}, {4'hA, 4'hA, 4'h5, 4'hC}};
    vecs[8] = '{2, {7'h01, 7'h02, 7'h7E, 7'h10}, {4'hE, 4'hD, 4'h1, 4'hF}};

    rstn       = 1'b0;
    load_start = 1'b0;
    load_abort = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    read_addr  = {7'h12, 7'h34, 7'h56, 7'h78};
    exp_page   = 1'b0;
    exp_ready  = 1'b0;
    prev_exp   = '0;
    prev_valid = 1'b0;

    // Reset state
    #12;
    chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    chk("rst_lut_ready", {31'd0, lut_ready}, 32'd0);
    chk("rst_active_page", {31'd0, active_page}, 32'd0);
    chk("rst_lut_data", lut_data, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // T1: reset in the middle of a load (wr_addr = 40)
    load_page(40, 1'b0, 2, "t1");
    // T2: first full load into page 1, data = addr[3:0]
    load_page(D, 1'b0, 0, "t2");
    rd_vec({7'h25, 7'h25, 7'h25, 7'h25}, {4'h5, 4'h5, 4'h5, 4'h5}, "t2_rd25");
    run_phase(0);
    // T3: ping-pong load of ~addr[3:0] into page 0
    load_page(D, 1'b1, 0, "t3");
    run_phase(1);
    // T4: abort after 50 beats, active page untouched
    load_page(50, 1'b0, 1, "t4");
    run_phase(2);
    // T4b: start and abort together in IDLE stays idle
    @(posedge clk); #1;
    load_start = 1'b1;
    load_abort = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    load_abort = 1'b0;
    chk("t4b_idle_ready", {31'd0, load_ready}, 32'd0);
    @(posedge clk); #1;
    chk("t4b_idle_ready2", {31'd0, load_ready}, 32'd0);
    chk("t4b_no_done", {31'd0, load_done}, 32'd0);
    chk("t4b_page", {31'd0, active_page}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
